// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the control sequencer
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'hF;

    localparam logic [1:0] RW_IDLE = 2'b00;
    localparam logic [1:0] RW_WR   = 2'b01;
    localparam logic [1:0] RW_RD   = 2'b10;
    localparam logic [1:0] RW_RDWR = 2'b11;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] dest;
        logic [3:0] srca;
        logic [3:0] srcb;
    } instr_fields_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational split of an instruction word into its fields
module instr_decode
    import ctrl_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0]  instr,
    output instr_fields_t  fields
);

    always_comb begin
        fields = instr_fields_t'(instr[15:0]);
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - IDLE/DECODE/EXEC/WB instruction sequencer
// Optional immediate-load path for opcode F is enabled by defining IMM_LOAD_EN.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          alu_done,
    output logic [AW-1:0] rf_DA,
    output logic [AW-1:0] rf_AA,
    output logic [AW-1:0] rf_BA,
    output logic [1:0]    rf_RW,
    output logic          rf_en,
    output logic [3:0]    alu_op,
    output logic          alu_start,
    output logic          d_sel,
    output logic [15:0]   imm,
    output logic          busy,
    output logic          err
);

    state_t        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          alu_start_q, alu_start_d;
    instr_fields_t fields;

    instr_decode #(.IW(IW)) u_decode (
        .instr  (instr_q),
        .fields (fields)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            alu_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_start_q <= alu_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready) begin
                    instr_d = instr;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (fields.opcode == OP_NOP) begin
                    state_d = ST_IDLE;
                end else if (fields.opcode == OP_LDI) begin
`ifdef IMM_LOAD_EN
                    state_d = ST_WB;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d     = ST_EXEC;
                    alu_start_d = 1'b1;
                end
            end
            // alu_done may arrive in the same cycle as the launch pulse
            ST_EXEC: begin
                if (alu_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE) && !rst;
        busy        = (state_q != ST_IDLE);
        rf_DA       = AW'(fields.dest);
        rf_AA       = AW'(fields.srca);
        rf_BA       = AW'(fields.srcb);
        alu_op      = fields.opcode;
        alu_start   = alu_start_q;
        rf_RW       = RW_IDLE;
        rf_en       = 1'b0;
        err         = 1'b0;
        d_sel       = 1'b0;
        imm         = '0;
        case (state_q)
            ST_DECODE: begin
`ifdef IMM_LOAD_EN
                if (fields.opcode != OP_LDI) begin
                    rf_RW = RW_RD;
                    rf_en = 1'b1;
                end
`else
                rf_RW = RW_RD;
                rf_en = 1'b1;
                err   = (fields.opcode == OP_LDI);
`endif
            end
            ST_WB: begin
                rf_RW = RW_WR;
                rf_en = 1'b1;
`ifdef IMM_LOAD_EN
                // opcode F only reaches WB through the immediate path
                if (fields.opcode == OP_LDI) begin
                    d_sel = 1'b1;
                    imm   = {8'h00, fields.srca, fields.srcb};
                end
`endif
            end
            default: begin
            end
        endcase
    end

endmodule
